// File: rtl/i2c_bus_arbiter.sv
// Shares one byte-level I2C master between two requesters, whole START..STOP transactions, round-robin.
// Latency: START handshake -> grant + m_valid next cycle; m_done -> r_rsp_valid next cycle.
// Backpressure: the non-owner's r_cmd_ready stays low; the master's m_ready holds commands; a watchdog forces STOP.
module i2c_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TW             = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  r_cmd_valid,
  input  logic [3:0]  r_cmd,
  input  logic [15:0] r_cmd_data,
  output logic [1:0]  r_cmd_ready,
  output logic [1:0]  r_grant,
  output logic [1:0]  r_rsp_valid,
  output logic [7:0]  r_rsp_data,
  output logic        r_rsp_nack,
  output logic [1:0]  r_err,
  output logic        m_valid,
  output logic [1:0]  m_cmd,
  output logic [7:0]  m_data,
  input  logic        m_ready,
  input  logic        m_done,
  input  logic [7:0]  m_rdata,
  input  logic        m_nack
);

  typedef enum logic [2:0] {S_IDLE, S_OWN, S_ISSUE, S_WAIT, S_FSTOP, S_FWAIT} state_e;

  localparam logic [1:0]    C_START = 2'b00;
  localparam logic [1:0]    C_READ  = 2'b10;
  localparam logic [1:0]    C_STOP  = 2'b11;
  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic          rr_q, rr_d;          // index of the requester that wins a START tie
  logic [1:0]    cmd_q, cmd_d;
  logic [7:0]    data_q, data_d;
  logic [TW-1:0] wdog_q, wdog_d;
  logic [1:0]    rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_data_q, rsp_data_d;
  logic          rsp_nack_q, rsp_nack_d;
  logic [1:0]    err_q, err_d;

  logic [1:0] cmd0, cmd1;
  logic [1:0] start_elig;
  logic       win1;
  logic       own1;
  logic       own_vld;

  assign cmd0       = r_cmd[1:0];
  assign cmd1       = r_cmd[3:2];
  assign start_elig = {r_cmd_valid[1] && (cmd1 == C_START), r_cmd_valid[0] && (cmd0 == C_START)};
  assign win1       = start_elig[1] && (!start_elig[0] || rr_q);
  assign own1       = grant_q[1];
  assign own_vld    = own1 ? r_cmd_valid[1] : r_cmd_valid[0];

  // Next-state, handshake and master-side outputs for the arbitration FSM.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    cmd_d       = cmd_q;
    data_d      = data_q;
    wdog_d      = '0;
    rsp_valid_d = '0;
    rsp_data_d  = '0;
    rsp_nack_d  = 1'b0;
    err_d       = '0;
    r_cmd_ready = '0;
    m_valid     = 1'b0;
    m_cmd       = 2'b00;
    m_data      = 8'h00;
    case (state_q)
      S_IDLE: begin
        // Anything other than START outside a transaction is swallowed and flagged.
        if (r_cmd_valid[0] && !start_elig[0]) begin
          r_cmd_ready[0] = 1'b1;
          err_d[0]       = 1'b1;
        end
        if (r_cmd_valid[1] && !start_elig[1]) begin
          r_cmd_ready[1] = 1'b1;
          err_d[1]       = 1'b1;
        end
        if (|start_elig) begin
          cmd_d   = C_START;
          state_d = S_ISSUE;
          if (win1) begin
            r_cmd_ready[1] = 1'b1;
            grant_d        = 2'b10;
            data_d         = r_cmd_data[15:8];
          end else begin
            r_cmd_ready[0] = 1'b1;
            grant_d        = 2'b01;
            data_d         = r_cmd_data[7:0];
          end
        end
      end
      S_OWN: begin
        if (own_vld) begin
          r_cmd_ready = grant_q;
          cmd_d       = own1 ? cmd1 : cmd0;
          data_d      = own1 ? r_cmd_data[15:8] : r_cmd_data[7:0];
          state_d     = S_ISSUE;
        end else if (wdog_q == WD_LAST) begin
          err_d   = grant_q;
          state_d = S_FSTOP;
        end else begin
          wdog_d = wdog_q + TW'(1);
        end
      end
      S_ISSUE: begin
        m_valid = 1'b1;
        m_cmd   = cmd_q;
        m_data  = data_q;
        if (m_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (m_done) begin
          rsp_valid_d = grant_q;
          rsp_data_d  = (cmd_q == C_READ) ? m_rdata : 8'h00;
          rsp_nack_d  = m_nack;
          if (cmd_q == C_STOP) begin
            grant_d = '0;
            rr_d    = ~grant_q[1];
            state_d = S_IDLE;
          end else begin
            state_d = S_OWN;
          end
        end
      end
      S_FSTOP: begin
        m_valid = 1'b1;
        m_cmd   = C_STOP;
        if (m_ready) state_d = S_FWAIT;
      end
      S_FWAIT: begin
        // Forced STOP completes silently; the stalled owner already saw r_err.
        if (m_done) begin
          grant_d = '0;
          rr_d    = ~grant_q[1];
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      rr_q        <= 1'b0;
      cmd_q       <= '0;
      data_q      <= '0;
      wdog_q      <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_nack_q  <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      cmd_q       <= cmd_d;
      data_q      <= data_d;
      wdog_q      <= wdog_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_nack_q  <= rsp_nack_d;
      err_q       <= err_d;
    end
  end

  assign r_grant     = grant_q;
  assign r_rsp_valid = rsp_valid_q;
  assign r_rsp_data  = rsp_data_q;
  assign r_rsp_nack  = rsp_nack_q;
  assign r_err       = err_q;

endmodule
